lcd_nibble_writer: RTL and testbench

Downstream output stage of the mini ALU core. It accepts one 8-bit byte per valid/ready handshake, with a register-select flag, and drives the 4-bit HD44780-style character LCD on the board. Each byte goes out as two nibbles, high nibble first. Setup, enable-pulse, hold, inter-nibble and post-command delays are cycle-counted, so the core never needs to busy-wait in software.

---
 rtl/lcd_nibble_writer_pkg.sv | 38 +++
 rtl/lcd_nibble_writer_delay.sv | 37 +++
 rtl/lcd_nibble_writer.sv | 151 +++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_nibble_writer_pkg.sv
// Shared definitions for the 4-bit character LCD writer.
// State codes, default delays and register-select encodings.
package lcd_nibble_writer_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_HI_SETUP = 4'd1;
  localparam logic [3:0] ST_HI_PULSE = 4'd2;
  localparam logic [3:0] ST_HI_HOLD  = 4'd3;
  localparam logic [3:0] ST_GAP      = 4'd4;
  localparam logic [3:0] ST_LO_SETUP = 4'd5;
  localparam logic [3:0] ST_LO_PULSE = 4'd6;
  localparam logic [3:0] ST_LO_HOLD  = 4'd7;
  localparam logic [3:0] ST_WAIT     = 4'd8;

  localparam int LCD_SETUP = 2;
  localparam int LCD_PULSE = 12;
  localparam int LCD_HOLD  = 1;
  localparam int LCD_GAP   = 50;
  localparam int LCD_WAIT  = 2000;

  localparam logic LCD_CMD  = 1'b0;
  localparam logic LCD_DATA = 1'b1;

  function automatic logic is_hi(input logic [3:0] s);
    return (s == ST_HI_SETUP) || (s == ST_HI_PULSE) ||
           (s == ST_HI_HOLD);
  endfunction

  function automatic logic is_lo(input logic [3:0] s);
    return (s == ST_LO_SETUP) || (s == ST_LO_PULSE) ||
           (s == ST_LO_HOLD);
  endfunction

  function automatic logic is_pulse(input logic [3:0] s);
    return (s == ST_HI_PULSE) || (s == ST_LO_PULSE);
  endfunction

endpackage

// File: rtl/lcd_nibble_writer_delay.sv
// Loadable down-counter used to time every LCD phase.
// Saturates at zero; oZero flags the last cycle of a phase.
module lcd_delay_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iValue,
  output logic             oZero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load on phase entry, otherwise count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (iLoad) begin
      cnt_d = iValue;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oZero = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Byte-to-nibble writer for an HD44780-style LCD in 4-bit mode.
// High nibble first; all strobe timing is cycle-counted.
module lcd_nibble_writer
  import lcd_nibble_writer_pkg::*;
#(
  parameter int SETUP_CYCLES = LCD_SETUP,
  parameter int PULSE_CYCLES = LCD_PULSE,
  parameter int HOLD_CYCLES  = LCD_HOLD,
  parameter int GAP_CYCLES   = LCD_GAP,
  parameter int WAIT_CYCLES  = LCD_WAIT,
  parameter int CNT_W        = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(WAIT_CYCLES - 1);

  logic [3:0]       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             rsl_q, rsl_d;
  logic             ready_q, ready_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [3:0]       data_q, data_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  lcd_delay_counter #(
    .CNT_W(CNT_W)
  ) u_delay (
    .Clock (Clock),
    .Reset (Reset),
    .iLoad (load),
    .iValue(load_val),
    .oZero (zero)
  );

  // next state: each timed phase ends when the counter hits zero
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    rsl_d    = rsl_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      ST_IDLE: if (iValid) begin
        state_d  = ST_HI_SETUP;
        byte_d   = iData;
        rsl_d    = iRS;
        load     = 1'b1;
        load_val = LD_SETUP;
      end
      ST_HI_SETUP: if (zero) begin
        state_d  = ST_HI_PULSE;
        load     = 1'b1;
        load_val = LD_PULSE;
      end
      ST_HI_PULSE: if (zero) begin
        state_d  = ST_HI_HOLD;
        load     = 1'b1;
        load_val = LD_HOLD;
      end
      ST_HI_HOLD: if (zero) begin
        state_d  = ST_GAP;
        load     = 1'b1;
        load_val = LD_GAP;
      end
      ST_GAP: if (zero) begin
        state_d  = ST_LO_SETUP;
        load     = 1'b1;
        load_val = LD_SETUP;
      end
      ST_LO_SETUP: if (zero) begin
        state_d  = ST_LO_PULSE;
        load     = 1'b1;
        load_val = LD_PULSE;
      end
      ST_LO_PULSE: if (zero) begin
        state_d  = ST_LO_HOLD;
        load     = 1'b1;
        load_val = LD_HOLD;
      end
      ST_LO_HOLD: if (zero) begin
        state_d  = ST_WAIT;
        load     = 1'b1;
        load_val = LD_WAIT;
      end
      ST_WAIT: if (zero) begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs decoded from the next state so they register cleanly
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    e_d     = is_pulse(state_d);
    data_d  = data_q;
    rs_d    = rs_q;
    if (is_hi(state_d)) begin
      data_d = byte_d[7:4];
      rs_d   = rsl_d;
    end else if (is_lo(state_d)) begin
      data_d = byte_d[3:0];
      rs_d   = rsl_d;
    end
  end

  // state, latched byte and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      byte_q  <= 8'h00;
      rsl_q   <= LCD_CMD;
      ready_q <= 1'b1;
      e_q     <= 1'b0;
      rs_q    <= LCD_CMD;
      data_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      rsl_q   <= rsl_d;
      ready_q <= ready_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign oReady    = ready_q;
  assign oLCD_E    = e_q;
  assign oLCD_RS   = rs_q;
  assign oLCD_RW   = 1'b0;
  assign oLCD_Data = data_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer: default timing and all-ones timing.
// Timeline model per instance plus directed literal checks.
module tb_lcd_nibble_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] vld = '0;
  logic [1:0] rsi = '0;
  logic [7:0] din0 = '0;
  logic [7:0] din1 = '0;
  logic [1:0] rdy, eo, rso, rwo;
  logic [3:0] dat0, dat1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  lcd_nibble_writer dut0 (
    .Clock(clk), .Reset(rst), .iData(din0), .iRS(rsi[0]),
    .iValid(vld[0]), .oReady(rdy[0]), .oLCD_E(eo[0]),
    .oLCD_RS(rso[0]), .oLCD_RW(rwo[0]), .oLCD_Data(dat0)
  );

  lcd_nibble_writer #(
    .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1),
    .GAP_CYCLES(1), .WAIT_CYCLES(1), .CNT_W(16)
  ) dut1 (
    .Clock(clk), .Reset(rst), .iData(din1), .iRS(rsi[1]),
    .iValid(vld[1]), .oReady(rdy[1]), .oLCD_E(eo[1]),
    .oLCD_RS(rso[1]), .oLCD_RW(rwo[1]), .oLCD_Data(dat1)
  );

  function automatic int ps(int i); return i == 0 ? 2 : 1; endfunction
  function automatic int pp(int i); return i == 0 ? 12 : 1; endfunction
  function automatic int ph(int i); return i == 0 ? 1 : 1; endfunction
  function automatic int pg(int i); return i == 0 ? 50 : 1; endfunction
  function automatic int pw(int i); return i == 0 ? 2000 : 1; endfunction

  function automatic int tt(int i);
    return 2 * (ps(i) + pp(i) + ph(i)) + pg(i) + pw(i);
  endfunction

  // 0 = high nibble, 1 = gap, 2 = low nibble, 3 = final wait
  function automatic int phase(int i, int t);
    int nib = ps(i) + pp(i) + ph(i);
    if (t < nib) return 0;
    if (t < nib + pg(i)) return 1;
    if (t < 2 * nib + pg(i)) return 2;
    return 3;
  endfunction

  function automatic bit e_at(int i, int t);
    int ph_n = phase(i, t);
    int off = (ph_n == 0) ? t : t - (ps(i) + pp(i) + ph(i)) - pg(i);
    if (ph_n == 1 || ph_n == 3) return 1'b0;
    return (off >= ps(i)) && (off < ps(i) + pp(i));
  endfunction

  bit         m_busy[2];
  int         m_t[2];
  logic [7:0] m_byte[2];
  logic       m_rsl[2];
  logic       m_e[2];
  logic       m_rs[2];
  logic [3:0] m_d[2];

  // timeline model: t counts edges since the accepting edge
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_t[i] = 0;
        m_e[i] = 1'b0;
        m_rs[i] = 1'b0;
        m_d[i] = 4'h0;
      end else begin
        if (!m_busy[i]) begin
          if (vld[i]) begin
            m_busy[i] = 1'b1;
            m_t[i] = 0;
            m_byte[i] = (i == 1) ? din1 : din0;
            m_rsl[i] = rsi[i];
          end
        end else begin
          m_t[i]++;
          if (m_t[i] >= tt(i)) m_busy[i] = 1'b0;
        end
        m_e[i] = m_busy[i] && e_at(i, m_t[i]);
        if (m_busy[i] && phase(i, m_t[i]) == 0) begin
          m_d[i] = m_byte[i][7:4];
          m_rs[i] = m_rsl[i];
        end else if (m_busy[i] && phase(i, m_t[i]) == 2) begin
          m_d[i] = m_byte[i][3:0];
          m_rs[i] = m_rsl[i];
        end
      end
    end
  end

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] got, want;
        got = {rdy[i], eo[i], rso[i], rwo[i],
               (i == 1) ? dat1 : dat0};
        want = {!m_busy[i], m_e[i], m_rs[i], 1'b0, m_d[i]};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL model cyc=%0d inst=%0d rdy/e/rs/rw/data got %b want %b",
                   cyc, i, got, want);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_xfer(
    input int inst, input logic [7:0] b, input logic r,
    output int rise0, output int w0, output int d0,
    output int rise1, output int w1, output int d1,
    output int rdy_n, output int rs_ok
  );
    int np;
    logic pe, ce;
    rise0 = -1; rise1 = -1; w0 = 0; w1 = 0;
    d0 = -1; d1 = -1; rdy_n = -1; rs_ok = 1;
    np = 0; pe = 1'b0;
    @(negedge clk);
    if (inst == 0) din0 = b; else din1 = b;
    rsi[inst] = r;
    vld[inst] = 1'b1;
    @(posedge clk);
    #1;
    vld[inst] = 1'b0;
    if (inst == 0) din0 = ~b; else din1 = ~b;
    rsi[inst] = ~r;
    for (int n = 0; n <= tt(inst) + 5; n++) begin
      @(negedge clk);
      ce = eo[inst];
      if (ce && !pe) begin
        if (np == 0) begin
          rise0 = n;
          d0 = int'(inst == 1 ? dat1 : dat0);
        end else begin
          rise1 = n;
          d1 = int'(inst == 1 ? dat1 : dat0);
        end
      end
      if (ce && np == 0) w0++;
      if (ce && np == 1) w1++;
      if (!ce && pe) np++;
      pe = ce;
      if (rdy[inst]) begin
        rdy_n = n;
        break;
      end
      if (rso[inst] !== r) rs_ok = 0;
    end
  endtask

  task automatic wait_ready(input int inst, input int budget);
    int n = 0;
    while (!rdy[inst] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", int'(rdy[inst]), 1);
  endtask

  int r0, w0, d0, r1, w1, d1, rn, rok;
  int acc[3];
  int k;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_ready", int'(rdy[0]), 1);
    chk("idle_e", int'(eo[0]), 0);
    chk("idle_rs", int'(rso[0]), 0);
    chk("idle_rw", int'(rwo[0]), 0);
    chk("idle_data", int'(dat0), 0);

    run_xfer(0, 8'h28, 1'b0, r0, w0, d0, r1, w1, d1, rn, rok);
    chk("x28_rise_hi", r0, 2);
    chk("x28_width_hi", w0, 12);
    chk("x28_nib_hi", d0, 2);
    chk("x28_rise_lo", r1, 67);
    chk("x28_width_lo", w1, 12);
    chk("x28_nib_lo", d1, 8);
    chk("x28_ready_at", rn, 2080);
    chk("x28_rs", rok, 1);

    run_xfer(0, 8'h41, 1'b1, r0, w0, d0, r1, w1, d1, rn, rok);
    chk("x41_nib_hi", d0, 4);
    chk("x41_nib_lo", d1, 1);
    chk("x41_width_hi", w0, 12);
    chk("x41_width_lo", w1, 12);
    chk("x41_rs_high", rok, 1);
    chk("x41_ready_at", rn, 2080);

    acc = '{0, 0, 0};
    k = 0;
    @(negedge clk);
    rsi[0] = 1'b0;
    vld[0] = 1'b1;
    for (int n = 0; n < 3 * 2081 + 100 && k < 3; n++) begin
      if (rdy[0]) begin
        din0 = 8'(k + 1);
        @(posedge clk);
        #1;
        acc[k] = cyc;
        din0 = 8'hA5 + 8'(k);
        rsi[0] = 1'b1;
        k++;
        if (k == 3) vld[0] = 1'b0;
      end
      @(negedge clk);
      rsi[0] = ~rsi[0];
    end
    rsi[0] = 1'b0;
    chk("b2b_accepts", k, 3);
    chk("b2b_space_01", acc[1] - acc[0], 2081);
    chk("b2b_space_12", acc[2] - acc[1], 2081);
    wait_ready(0, 2200);

    @(negedge clk);
    din0 = 8'hFF;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pre_e", int'(eo[0]), 1);
    chk("rst_pre_data", int'(dat0), 15);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_e", int'(eo[0]), 0);
    chk("rst_async_data", int'(dat0), 0);
    chk("rst_async_ready", int'(rdy[0]), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_ready", int'(rdy[0]), 1);

    run_xfer(0, 8'h30, 1'b0, r0, w0, d0, r1, w1, d1, rn, rok);
    chk("x30_nib_hi", d0, 3);
    chk("x30_nib_lo", d1, 0);
    chk("x30_ready_at", rn, 2080);

    run_xfer(1, 8'h5A, 1'b1, r0, w0, d0, r1, w1, d1, rn, rok);
    chk("fast_rise_hi", r0, 1);
    chk("fast_width_hi", w0, 1);
    chk("fast_nib_hi", d0, 5);
    chk("fast_rise_lo", r1, 5);
    chk("fast_width_lo", w1, 1);
    chk("fast_nib_lo", d1, 10);
    chk("fast_ready_at", rn, 8);
    chk("fast_rs", rok, 1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
